// File: rtl/layer_mapper_pkg.sv
// rtl/layer_mapper_pkg.sv - shared types and default parameters for layer_mapper
//
// Purpose: fade FSM state encoding, packed RGB pixel type and the default
//          parameter values used by layer_mapper and layer_palette.
// Ports:   none (package).

package layer_mapper_pkg;

   localparam int NUM_LAYERS_DEF = 4;
   localparam int COLOR_W_DEF    = 8;
   localparam int PAL_AW_DEF     = 4;
   localparam int FADE_BITS_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FADE_OUT = 2'd1,
      BLACK    = 2'd2,
      FADE_IN  = 2'd3
   } fade_state_t;

   typedef struct packed {
      logic [COLOR_W_DEF-1:0] r;
      logic [COLOR_W_DEF-1:0] g;
      logic [COLOR_W_DEF-1:0] b;
   } rgb_t;

endpackage

// File: rtl/layer_palette.sv
// rtl/layer_palette.sv - colour palette RAM with write-to-read forwarding
//
// Purpose: 2**AW entries of DW bits, synchronous write, read of a registered
//          address. A write to the entry being read in the same cycle is
//          forwarded so the reader never sees stale data.
// Ports:   clk, rst_n      clock, asynchronous active-low reset (clears RAM)
//          we/waddr/wdata  write port
//          raddr/rdata     read port (raddr is driven from a register)

module layer_palette #(
   parameter int AW = 4,
   parameter int DW = 24
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/layer_mapper.sv
// rtl/layer_mapper.sv - priority layer mux, palette lookup and frame fade
//
// Purpose: two-stage pixel pipeline. Stage 1 picks the highest-priority
//          covering layer (bit 0 wins) or the background; stage 2 reads the
//          palette, scales by the fade level and registers VGA_*. A fade FSM
//          steps the level once per frame tick.
// Ports:   Clk, Reset_n                 clock, asynchronous active-low reset
//          DrawX, DrawY, pix_valid      pixel position / qualifier
//          layer_hit, layer_idx, bg_rgb colour sources
//          pal_we, pal_addr, pal_wdata  palette write port
//          fade_start, fade_dir         fade request
//          VGA_R/G/B, out_valid         pixel output, 2 cycles after input
//          fade_busy                    fade FSM not idle

module layer_mapper
   import layer_mapper_pkg::*;
#(
   parameter int NUM_LAYERS = NUM_LAYERS_DEF,
   parameter int COLOR_W    = COLOR_W_DEF,
   parameter int PAL_AW     = PAL_AW_DEF,
   parameter int FADE_BITS  = FADE_BITS_DEF
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic [9:0]                   DrawX,
   input  logic [9:0]                   DrawY,
   input  logic                         pix_valid,
   input  logic [NUM_LAYERS-1:0]        layer_hit,
   input  logic [NUM_LAYERS*PAL_AW-1:0] layer_idx,
   input  logic [3*COLOR_W-1:0]         bg_rgb,
   input  logic                         pal_we,
   input  logic [PAL_AW-1:0]            pal_addr,
   input  logic [3*COLOR_W-1:0]         pal_wdata,
   input  logic                         fade_start,
   input  logic                         fade_dir,
   output logic [COLOR_W-1:0]           VGA_R,
   output logic [COLOR_W-1:0]           VGA_G,
   output logic [COLOR_W-1:0]           VGA_B,
   output logic                         out_valid,
   output logic                         fade_busy
);

   localparam int PROD_W = COLOR_W + FADE_BITS + 1;
   localparam logic [FADE_BITS:0] LVL_ZERO = '0;
   localparam logic [FADE_BITS:0] LVL_ONE  = {{FADE_BITS{1'b0}}, 1'b1};
   localparam logic [FADE_BITS:0] LVL_TOP  = {1'b0, {FADE_BITS{1'b1}}};
   localparam logic [FADE_BITS:0] LVL_FULL = {1'b1, {FADE_BITS{1'b0}}};

   fade_state_t           state;
   logic [FADE_BITS:0]    level;
   logic                  frame_tick;

   logic                  hit_any;
   logic [PAL_AW-1:0]     hit_sel;

   logic                  s1_valid;
   logic                  s1_use_pal;
   logic [PAL_AW-1:0]     s1_idx;
   logic [3*COLOR_W-1:0]  s1_bg;

   logic [3*COLOR_W-1:0]  pal_rdata;
   logic [3*COLOR_W-1:0]  src;

   assign frame_tick = pix_valid && (DrawX == '0) && (DrawY == '0);

   // Scan from the lowest priority upward so the lowest set index is the last
   // assignment and therefore wins.
   always_comb begin
      hit_any = 1'b0;
      hit_sel = '0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (layer_hit[i]) begin
            hit_any = 1'b1;
            hit_sel = layer_idx[i*PAL_AW +: PAL_AW];
         end
      end
   end

   // Level is at most 2**FADE_BITS, so full level reproduces c exactly.
   function automatic logic [COLOR_W-1:0] fade_scale(input logic [COLOR_W-1:0] c,
                                                     input logic [FADE_BITS:0] lvl);
      logic [PROD_W-1:0] prod;
      prod = {{(FADE_BITS+1){1'b0}}, c} * {{COLOR_W{1'b0}}, lvl};
      return COLOR_W'(prod >> FADE_BITS);
   endfunction

   layer_palette #(
      .AW (PAL_AW),
      .DW (3*COLOR_W)
   ) u_palette (
      .clk   (Clk),
      .rst_n (Reset_n),
      .we    (pal_we),
      .waddr (pal_addr),
      .wdata (pal_wdata),
      .raddr (s1_idx),
      .rdata (pal_rdata)
   );

   assign src = s1_use_pal ? pal_rdata : s1_bg;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s1_valid   <= 1'b0;
         s1_use_pal <= 1'b0;
         s1_idx     <= '0;
         s1_bg      <= '0;
         out_valid  <= 1'b0;
         VGA_R      <= '0;
         VGA_G      <= '0;
         VGA_B      <= '0;
      end else begin
         s1_valid   <= pix_valid;
         s1_use_pal <= hit_any;
         s1_idx     <= hit_sel;
         s1_bg      <= bg_rgb;
         out_valid  <= s1_valid;
         if (s1_valid) begin
            VGA_R <= fade_scale(src[2*COLOR_W +: COLOR_W], level);
            VGA_G <= fade_scale(src[COLOR_W +: COLOR_W], level);
            VGA_B <= fade_scale(src[0 +: COLOR_W], level);
         end
      end
   end

   // Only one branch runs per cycle, so a request that coincides with a
   // frame tick moves the state and the level step waits for the next tick.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= IDLE;
         level     <= LVL_FULL;
         fade_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (fade_start) begin
                  state     <= fade_dir ? FADE_IN : FADE_OUT;
                  fade_busy <= 1'b1;
               end
            end
            FADE_OUT: begin
               if (level == LVL_ZERO) begin
                  state <= BLACK;
               end else if (frame_tick) begin
                  level <= level - LVL_ONE;
                  if (level == LVL_ONE) state <= BLACK;
               end
            end
            BLACK: begin
               if (fade_start && fade_dir) state <= FADE_IN;
            end
            FADE_IN: begin
               if (level == LVL_FULL) begin
                  state     <= IDLE;
                  fade_busy <= 1'b0;
               end else if (frame_tick) begin
                  level <= level + LVL_ONE;
                  if (level == LVL_TOP) begin
                     state     <= IDLE;
                     fade_busy <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               fade_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer_mapper.sv
// tb/tb_layer_mapper.sv - self-checking bench for layer_mapper

module tb_layer_mapper;
   import layer_mapper_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [9:0]  DrawX, DrawY;
   logic        pix_valid;
   logic [3:0]  layer_hit;
   logic [15:0] layer_idx;
   logic [23:0] bg_rgb;
   logic        pal_we;
   logic [3:0]  pal_addr;
   logic [23:0] pal_wdata;
   logic        fade_start, fade_dir;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic        out_valid, fade_busy;

   layer_mapper dut (
      .Clk(clk), .Reset_n(rst_n), .DrawX(DrawX), .DrawY(DrawY),
      .pix_valid(pix_valid), .layer_hit(layer_hit), .layer_idx(layer_idx),
      .bg_rgb(bg_rgb), .pal_we(pal_we), .pal_addr(pal_addr),
      .pal_wdata(pal_wdata), .fade_start(fade_start), .fade_dir(fade_dir),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .out_valid(out_valid), .fade_busy(fade_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 0;

   // reference model: palette contents, fade level and mode, one held pixel
   int unsigned m_pal [16];
   int          m_lvl;
   int          m_mode;   // 0 idle, 1 darkening, 2 black, 3 brightening
   bit          p_v;
   logic [3:0]  p_hit;
   logic [15:0] p_idx;
   logic [23:0] p_bg;
   bit          exp_v, exp_busy;
   int unsigned exp_r, exp_g, exp_b;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic int unsigned scale(input int unsigned c, input int l);
      return (c * l) / 16;
   endfunction

   task automatic model_reset();
      foreach (m_pal[i]) m_pal[i] = 0;
      m_lvl = 16; m_mode = 0;
      p_v = 0; exp_v = 0; exp_busy = 0;
      exp_r = 0; exp_g = 0; exp_b = 0;
   endtask

   task automatic model_step();
      int unsigned col;
      bit found;
      bit tick;
      if (pal_we) m_pal[pal_addr] = pal_wdata;
      exp_v = p_v;
      if (p_v) begin
         col = p_bg; found = 0;
         for (int i = 0; i < 4; i++) begin
            if (!found && p_hit[i]) begin
               found = 1;
               col = m_pal[(p_idx >> (4*i)) & 15];
            end
         end
         exp_r = scale((col >> 16) & 255, m_lvl);
         exp_g = scale((col >> 8) & 255, m_lvl);
         exp_b = scale(col & 255, m_lvl);
      end
      tick = pix_valid && DrawX == 0 && DrawY == 0;
      case (m_mode)
         0: if (fade_start) m_mode = fade_dir ? 3 : 1;
         1: begin
            if (tick && m_lvl > 0) m_lvl--;
            if (m_lvl == 0) m_mode = 2;
         end
         2: if (fade_start && fade_dir) m_mode = 3;
         default: begin
            if (tick && m_lvl < 16) m_lvl++;
            if (m_lvl == 16) m_mode = 0;
         end
      endcase
      exp_busy = (m_mode != 0);
      p_v = pix_valid; p_hit = layer_hit; p_idx = layer_idx; p_bg = bg_rgb;
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("out_valid", out_valid, exp_v);
         check("fade_busy", fade_busy, exp_busy);
         if (exp_v) begin
            check("VGA_R", VGA_R, exp_r);
            check("VGA_G", VGA_G, exp_g);
            check("VGA_B", VGA_B, exp_b);
         end
      end
   end

   task automatic cyc();
      model_step();
      @(negedge clk);
   endtask

   task automatic clr();
      pix_valid = 0; layer_hit = 0; layer_idx = 0; bg_rgb = 0;
      pal_we = 0; pal_addr = 0; pal_wdata = 0;
      fade_start = 0; fade_dir = 0; DrawX = 10'd1; DrawY = 10'd1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) begin
         clr(); pix_valid = 1; DrawX = 0; DrawY = 0; bg_rgb = 24'h102030;
         cyc();
      end
   endtask

   task automatic start_fade(input bit dir);
      clr(); fade_start = 1; fade_dir = dir; cyc();
   endtask

   // single non-tick pixel, output visible on return
   task automatic probe(input logic [23:0] bg);
      clr(); pix_valid = 1; DrawX = 10'd7; bg_rgb = bg; cyc();
      clr(); cyc();
   endtask

   task automatic lit_rgb(input string name, input logic [23:0] want);
      rgb_t w;
      w = want;
      check({name, "_R"}, VGA_R, w.r);
      check({name, "_G"}, VGA_G, w.g);
      check({name, "_B"}, VGA_B, w.b);
      check({name, "_valid"}, out_valid, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; clr();
      model_reset();
      @(negedge clk); @(negedge clk);
      check("rst_VGA", {VGA_R, VGA_G, VGA_B}, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_fade_busy", fade_busy, 0);
      rst_n = 1; chk_en = 1;

      // priority: layer 1 beats layer 2
      clr(); pal_we = 1; pal_addr = 3; pal_wdata = 24'hFF0000; cyc();
      clr(); pal_we = 1; pal_addr = 5; pal_wdata = 24'h00AA55; cyc();
      clr(); pix_valid = 1; DrawX = 3; layer_hit = 4'b0110; layer_idx = 16'h0530; cyc();
      clr(); cyc();
      lit_rgb("priority", 24'hFF0000);

      // background bypass
      probe(24'h3F007F);
      lit_rgb("background", 24'h3F007F);

      // same-cycle write forwarded into the stage-2 read
      clr(); pix_valid = 1; DrawX = 3; layer_hit = 4'b0001; layer_idx = 16'h0003; cyc();
      clr(); pal_we = 1; pal_addr = 3; pal_wdata = 24'h00FF00; cyc();
      lit_rgb("forward", 24'h00FF00);

      // fade out, requests ignored mid-fade
      start_fade(0);
      ticks(7);
      check("model_lvl9", m_lvl, 9);
      start_fade(1);
      start_fade(0);
      probe(24'hF0F0F0);
      lit_rgb("lvl9", 24'h878787);
      ticks(1);
      probe(24'hF0F0F0);
      lit_rgb("lvl8", 24'h787878);
      ticks(8);
      check("black_busy", fade_busy, 1);
      probe(24'hFFFFFF);
      lit_rgb("black", 24'h000000);
      start_fade(0);
      probe(24'hFFFFFF);
      lit_rgb("black_ignore", 24'h000000);
      check("black_ignore_busy", fade_busy, 1);

      // fade back in
      start_fade(1);
      ticks(16);
      check("idle_busy", fade_busy, 0);
      probe(24'hFFFFFF);
      lit_rgb("full", 24'hFFFFFF);

      // reset mid fade-in at level 5
      start_fade(0); ticks(16);
      start_fade(1); ticks(5);
      check("model_lvl5", m_lvl, 5);
      for (int k = 0; k < 3; k++) begin
         clr(); pix_valid = 1; DrawX = 9; bg_rgb = 24'hFFFFFF; cyc();
      end
      lit_rgb("lvl5", 24'h4F4F4F);
      #2;
      chk_en = 0; rst_n = 0;
      #1;
      check("async_rst_VGA", {VGA_R, VGA_G, VGA_B}, 0);
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_busy", fade_busy, 0);
      @(negedge clk); @(negedge clk);
      model_reset(); clr();
      rst_n = 1; chk_en = 1;
      cyc();
      probe(24'hFFFFFF);
      lit_rgb("post_rst", 24'hFFFFFF);

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         pix_valid  = ($urandom % 4) != 0;
         layer_hit  = 4'($urandom);
         layer_idx  = 16'($urandom);
         bg_rgb     = 24'($urandom);
         DrawX      = ($urandom % 4 == 0) ? 10'd0 : 10'($urandom_range(1, 639));
         DrawY      = ($urandom % 2 == 0) ? 10'd0 : 10'($urandom_range(1, 479));
         pal_we     = ($urandom % 3) == 0;
         pal_addr   = 4'($urandom);
         pal_wdata  = 24'($urandom);
         fade_start = ($urandom % 25) == 0;
         fade_dir   = 1'($urandom);
         cyc();
      end
      clr(); cyc(); cyc(); cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/layer_mapper.md
LAYER_MAPPER -- requirements
Module: layer_mapper

Interface
REQ-001 Parameter NUM_LAYERS, default 4: number of priority-ordered foreground layers (sprites, projectiles, text); range 1..8.
REQ-002 Parameter COLOR_W, default 8: bits per colour channel.
REQ-003 Parameter PAL_AW, default 4: palette address width; the palette holds 2**PAL_AW entries of 3*COLOR_W bits.
REQ-004 Parameter FADE_BITS, default 4: fade level width; full brightness = 2**FADE_BITS.
REQ-005 Clk  in  1  system clock; all state rises on posedge Clk.
REQ-006 Reset_n  in  1  asynchronous, active-low reset.
REQ-007 DrawX, DrawY  in  10 each  current pixel coordinates.
REQ-008 pix_valid  in  1  pixel inputs are valid this cycle.
REQ-009 layer_hit  in  NUM_LAYERS  bit i set means layer i covers the pixel; bit 0 has highest priority.
REQ-010 layer_idx  in  NUM_LAYERS*PAL_AW  palette index for each layer; layer i occupies slice [i*PAL_AW +: PAL_AW].
REQ-011 bg_rgb  in  3*COLOR_W  background colour as {R,G,B}, used when no layer hits.
REQ-012 pal_we, pal_addr[PAL_AW], pal_wdata[3*COLOR_W]  in  palette write port.
REQ-013 fade_start  in  1  pulse that requests a fade.
REQ-014 fade_dir  in  1  fade direction: 0 = fade to black, 1 = fade from black.
REQ-015 VGA_R, VGA_G, VGA_B  out  COLOR_W each  registered colour outputs.
REQ-016 out_valid  out  1  pix_valid delayed by 2 cycles.
REQ-017 fade_busy  out  1  high while the fade FSM is not idle.

Function
REQ-018 Latency SHALL be exactly 2 cycles from pixel inputs to VGA_*/out_valid; the pipeline SHALL accept one pixel per cycle with no stalls.
REQ-019 Stage 1 SHALL register the pixel's colour source: the lowest-index i with layer_hit[i]=1 selects palette entry layer_idx slice i; if layer_hit is all zero, the source is bg_rgb, which bypasses the palette.
REQ-020 Stage 2 SHALL read the palette, apply fade scaling, and register VGA_*.
REQ-021 Fade scaling: each channel out = (c * level) >> FADE_BITS, computed at COLOR_W+FADE_BITS+1 bits; when level = 2**FADE_BITS the output equals the input exactly.
REQ-022 A palette write updates the entry at the next posedge; if a stage-2 read hits the address being written in the same cycle, pal_wdata SHALL be forwarded to the read.
REQ-023 A frame tick SHALL be asserted when pix_valid & DrawX==0 & DrawY==0.
REQ-024 The fade FSM SHALL have states IDLE, FADE_OUT, BLACK, FADE_IN.
REQ-025 IDLE + fade_start & !fade_dir -> FADE_OUT; IDLE + fade_start & fade_dir -> FADE_IN.
REQ-026 In FADE_OUT, level SHALL decrement by 1 per frame tick; at level 0 the FSM SHALL go to BLACK.
REQ-027 In BLACK, fade_start & fade_dir -> FADE_IN; a fade_start with fade_dir=0 SHALL be ignored.
REQ-028 In FADE_IN, level SHALL increment by 1 per frame tick; at level 2**FADE_BITS the FSM SHALL go to IDLE.
REQ-029 fade_start while in FADE_OUT or FADE_IN SHALL be ignored; level SHALL never wrap below 0 or above 2**FADE_BITS.
REQ-030 A fade_start coincident with a frame tick SHALL change state only; the level step begins at the next tick.
REQ-031 fade_busy SHALL be 1 in FADE_OUT, FADE_IN and BLACK.

Reset
REQ-032 Reset_n low SHALL force VGA_*=0, out_valid=0, both pipeline stages invalid, FSM=IDLE, level=2**FADE_BITS and fade_busy=0.
REQ-033 Palette contents SHALL reset to all-zero.
REQ-034 Assertion of Reset_n mid-fade SHALL abort the fade with no residual state; the first out_valid after release comes 2 cycles after the first pix_valid.

Structure
REQ-035 A shared package SHALL hold the fade_state_t enum, the rgb_t packed struct and the default-parameter constants.
REQ-036 The palette SHALL be a sub-module, layer_palette: synchronous write, registered read with forwarding.
REQ-037 The priority encoder and fade multiply SHALL stay inline.

Verification
REQ-038 Priority: layer_hit=4'b0110, idx1=3, idx2=5, pal[3]=0xFF0000 -> VGA=FF,00,00 two cycles later.
REQ-039 Background: layer_hit=0, bg_rgb=0x3F007F, level full -> VGA=3F,00,7F with out_valid high at +2.
REQ-040 Forwarding: pal_we to addr 3 with 0x00FF00 in the same cycle as a stage-2 read of entry 3 -> VGA=00,FF,00.
REQ-041 Fade: fade_start, fade_dir=0, FADE_BITS=4 -> after 16 frame ticks FSM=BLACK and a 0xFFFFFF pixel outputs 0; after fade_dir=1 and 16 more ticks, IDLE with output FF.
REQ-042 Ignore: fade_start during FADE_OUT at level 9 -> level continues 8, 7, ...; fade_start with dir=0 in BLACK -> no change.
REQ-043 Reset: Reset_n low during FADE_IN at level 5 -> level=16, IDLE, outputs 0, out_valid=0 immediately, asynchronously.
